s2mm_result_writer: RTL and testbench
=====================================

Name: s2mm_result_writer

Overview:
- Consumes the S2MM AXI-Stream that load_fetch emits after the softmax pass.
- Writes each 32-bit result word into the result BRAM (blk_mem port A) starting at word address 131072. Word layout: [31:16] class index, [15:0] probability in Q4.12.
- Armed by the GPIO start code.
- Reports completion, the beat count and framing errors, so the bench and the PS can tell when the 4800-entry result region is valid.

Parameters:
- DATA_W, 32, stream and BRAM data width.
- ADDR_W, 18, BRAM word-address width.
- BASE_ADDR, 131072, first BRAM word address of the result region.
- FRAME_LEN, 4800, expected beats per frame. Legal range 1..2^ADDR_W-BASE_ADDR.
- START_CODE, 8'hAA, value of gpio_io_o[7:0] that arms the block.

Ports:
- aclk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- gpio_io_o  in  32  GPIO command word; only bits [7:0] are used.
- s_axis_tdata  in  DATA_W  result word.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  beat accept.
- bram_addra  out  ADDR_W  BRAM word address.
- bram_dina  out  DATA_W  BRAM write data.
- bram_ena  out  1  BRAM port enable.
- bram_wea  out  1  BRAM write enable.
- busy  out  1  frame in progress (RUN or DRAIN).
- done  out  1  frame finished; held until the next arm.
- err_short  out  1  tlast arrived before FRAME_LEN beats.
- err_long  out  1  FRAME_LEN beats accepted without tlast.
- beat_cnt  out  ADDR_W  beats written in the current or last frame.

Behaviour:
- Reset: clock aclk, reset rst_n, asynchronous and active-low.
  - All outputs clear to 0.
  - State goes to IDLE and the start-edge register clears.
  - Reset asserted mid-frame abandons the frame; words already written stay in BRAM.
- Start detect:
  - arm = (gpio_io_o[7:0]==START_CODE) && !prev_match, where prev_match is registered each cycle.
  - Holding 0xAA produces only one arm. Code must return to non-0xAA and back to re-arm.
  - arm in RUN or DRAIN is ignored.
- States:
  - IDLE:
    - tready=0.
    - On arm: go to RUN; clear beat_cnt, done, err_short, err_long.
  - RUN:
    - tready=1. A beat is tvalid && tready.
    - Each beat registers addr=BASE_ADDR+beat_cnt, din=tdata, ena=wea=1 on the next cycle (write latency 1 cycle from the accepting edge), and increments beat_cnt.
    - Beat with tlast and beat_cnt==FRAME_LEN-1: written, go to DONE.
    - Beat with tlast and beat_cnt<FRAME_LEN-1: written, err_short=1, go to DONE.
    - Beat without tlast and beat_cnt==FRAME_LEN-1: written, err_long=1, go to DRAIN.
  - DRAIN:
    - tready=1. Beats are accepted and discarded: no BRAM write, beat_cnt frozen at FRAME_LEN.
    - Beat with tlast: go to DONE.
  - DONE:
    - tready=0, done=1, busy=0.
    - On arm: go to RUN with all flags and the count cleared, the same as from IDLE.
- Write-port pulses:
  - ena and wea are single-cycle pulses per beat. Back-to-back beats give continuous pulses.
  - Outside a write pulse, ena=wea=0 and addra/dina hold their last values.
- tvalid low: no beat, no write, state unchanged.
- Address never exceeds BASE_ADDR+FRAME_LEN-1. No wrap-around is possible because DRAIN suppresses writes.
- tready is combinational from state only and never depends on tvalid.
- busy = (state==RUN || state==DRAIN).
- done rises in the cycle after the final accepted beat, the same cycle as the last wea pulse.

Test Plan:
1. Nominal frame.
   - Stimulus: reset, then gpio 0x00 → 0xAA at 1000 ns; stream 4800 beats with tdata={i[15:0],16'h1000}, tlast on beat 4799, tvalid always high.
   - Required: 4800 wea pulses at addra 131072..135871; memory[131072+i][31:16]=i and [15:0]=4096; done=1; beat_cnt=4800; no errors.
2. Bubbles.
   - Stimulus: as scenario 1 but tvalid toggles 1/0 every cycle.
   - Required: same memory image and count; total frame time ≈ 2× scenario 1.
3. Short frame.
   - Stimulus: tlast on beat 99.
   - Required: 100 writes (131072..131171); err_short=1; done=1; beat_cnt=100.
4. Long frame.
   - Stimulus: 4810 beats, tlast on the last one.
   - Required: exactly 4800 writes; err_long=1; beats 4800..4809 accepted with no wea; done after beat 4809.
5. Arm rules.
   - Stimulus: hold 0xAA for 1100 ns; re-drive 0xAA mid-frame.
   - Required: single arm, frame unaffected. Then 0x00 → 0xAA after done: done clears and a new frame runs.
6. Reset mid-frame.
   - Stimulus: assert rst_n=0 after beat 2000.
   - Required: all outputs 0 within the reset; IDLE with tready=0; a subsequent arm restarts writing at 131072.

Source files
------------

// File: rtl/s2mm_result_writer_if.sv
// s2mm_result_writer_if: groups the S2MM AXI-Stream slave channel and the
// result-BRAM port A write signals of s2mm_result_writer.
//   s_axis_tdata/tvalid/tlast  stream source -> writer
//   s_axis_tready              writer -> stream source
//   bram_addra/dina/ena/wea    writer -> BRAM port A
// Modports: slave  = the writer (consumes the stream, drives the BRAM port)
//           master = the environment (drives the stream, observes the BRAM port)
interface s2mm_result_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_dina;
  logic              bram_ena;
  logic              bram_wea;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output bram_addra, bram_dina, bram_ena, bram_wea
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  bram_addra, bram_dina, bram_ena, bram_wea
  );
endinterface

// File: rtl/s2mm_result_writer.sv
// s2mm_result_writer: writes the post-softmax S2MM result stream into the
// result BRAM region starting at BASE_ADDR, one 32-bit word per beat
// ([31:16] class index, [15:0] Q4.12 probability). A frame is armed by a
// rising match of gpio_io_o[7:0] against START_CODE.
// Ports:
//   aclk, rst_n     clock (rising edge), asynchronous active-low reset
//   gpio_io_o       GPIO command word, bits [7:0] compared to START_CODE
//   bus (slave)     AXI-Stream input + BRAM port A write outputs
//   busy            frame in progress (RUN or DRAIN)
//   done            frame finished, held until the next arm
//   err_short       tlast arrived before FRAME_LEN beats
//   err_long        FRAME_LEN beats accepted without tlast
//   beat_cnt        beats written in the current or last frame
module s2mm_result_writer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned BASE_ADDR  = 131072,
  parameter int unsigned FRAME_LEN  = 4800,
  parameter logic [7:0]  START_CODE = 8'hAA
) (
  input  logic                   aclk,
  input  logic                   rst_n,
  input  logic [31:0]            gpio_io_o,
  s2mm_result_writer_if.slave    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err_short,
  output logic                   err_long,
  output logic [ADDR_W-1:0]      beat_cnt
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_prev_match;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_wen;
  logic                r_err_short;
  logic                r_err_long;

  logic                w_match;
  logic                w_arm;
  logic                w_tready;
  logic                w_beat;
  logic                w_write;
  logic                w_start;
  logic                w_unused_gpio;

  assign w_unused_gpio = ^gpio_io_o[31:8];

  // Arm only on the cycle the code first matches; holding it does not re-arm.
  assign w_match  = (gpio_io_o[7:0] == START_CODE);
  assign w_arm    = w_match && !r_prev_match;

  assign w_tready = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_beat   = bus.s_axis_tvalid && w_tready;
  assign w_write  = w_beat && (r_state == S_RUN);
  assign w_start  = w_arm && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prev_match <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_prev_match <= w_match;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_arm) w_next = S_RUN;
      S_RUN: begin
        if (w_beat) begin
          if (bus.s_axis_tlast)   w_next = S_DONE;
          else if (r_cnt == LP_LAST) w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (w_beat && bus.s_axis_tlast) w_next = S_DONE;
      S_DONE:  if (w_arm) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Write port registers: addr/din only update on an accepted RUN beat so
  // they hold their last values between pulses; DRAIN never writes, which
  // keeps the address inside the result region.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_wen       <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_wen <= w_write;
      if (w_start) begin
        r_cnt       <= '0;
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
      end else if (w_write) begin
        r_addr <= LP_BASE + r_cnt;
        r_din  <= bus.s_axis_tdata;
        r_cnt  <= r_cnt + 1'b1;
        if (bus.s_axis_tlast && (r_cnt != LP_LAST))
          r_err_short <= 1'b1;
        if (!bus.s_axis_tlast && (r_cnt == LP_LAST))
          r_err_long <= 1'b1;
      end
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.bram_addra    = r_addr;
  assign bus.bram_dina     = r_din;
  assign bus.bram_ena      = r_wen;
  assign bus.bram_wea      = r_wen;

  assign busy      = w_tready;
  assign done      = (r_state == S_DONE);
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_s2mm_result_writer.sv
// tb_s2mm_result_writer: directed bench for s2mm_result_writer.
// A negedge monitor captures every BRAM write into a local image, checks the
// address sequence against BASE_ADDR+n and records done at each write.
module tb_s2mm_result_writer;

  localparam int unsigned BASE = 131072;
  localparam int unsigned FLEN = 4800;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio;
  logic        busy, done, err_short, err_long;
  logic [17:0] beat_cnt;

  s2mm_result_writer_if #(.DATA_W(32), .ADDR_W(18)) bus ();

  s2mm_result_writer #(
    .DATA_W    (32),
    .ADDR_W    (18),
    .BASE_ADDR (BASE),
    .FRAME_LEN (FLEN),
    .START_CODE(8'hAA)
  ) dut (
    .aclk     (clk),
    .rst_n    (rst_n),
    .gpio_io_o(gpio),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err_short(err_short),
    .err_long (err_long),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int wr_cnt, addr_err, ew_err, done_at_wr;
  logic [31:0] mem [0:FLEN-1];

  always @(negedge clk) begin
    if (bus.bram_ena !== bus.bram_wea) ew_err++;
    if (bus.bram_wea === 1'b1) begin
      if (bus.bram_addra !== 18'(BASE + wr_cnt)) addr_err++;
      if (wr_cnt < FLEN) mem[wr_cnt] = bus.bram_dina;
      else addr_err++;
      if (done === 1'b1) done_at_wr++;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wr_cnt = 0; addr_err = 0; ew_err = 0; done_at_wr = 0;
  endtask

  task automatic arm();
    @(negedge clk) gpio = 32'h0;
    @(negedge clk) gpio = 32'h0000_00AA;
  endtask

  // Sends beats first..first+n-1 with data {idx,16'h1000}; tlast on last_idx.
  task automatic stream(input int first, input int n, input int last_idx, input bit bub);
    int waits;
    for (int i = first; i < first + n; i++) begin
      bus.s_axis_tdata  = {i[15:0], 16'h1000};
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = (i == last_idx);
      waits = 0;
      while (bus.s_axis_tready !== 1'b1 && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 50) begin
        chk("tready_timeout", 32'(i), 32'hFFFF_FFFF);
        bus.s_axis_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
      if (bub) begin
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic chk_image(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (mem[i] !== {i[15:0], 16'h1000}) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tready"}, 32'(bus.s_axis_tready), 32'd0);
    chk({tag, "_enawea"}, {30'd0, bus.bram_ena, bus.bram_wea}, 32'd0);
    chk({tag, "_addra"},  32'(bus.bram_addra), 32'd0);
    chk({tag, "_dina"},   bus.bram_dina, 32'd0);
    chk({tag, "_flags"},  {28'd0, busy, done, err_short, err_long}, 32'd0);
    chk({tag, "_cnt"},    32'(beat_cnt), 32'd0);
  endtask

  time t0, t_nom, t_bub;

  initial begin
    rst_n = 1'b0;
    gpio  = 32'h0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    clr_mon();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // 1. Nominal frame, arm at ~1000 ns
    while ($time < 1000) @(negedge clk);
    gpio = 32'h0000_00AA;
    t0 = $time;
    stream(0, FLEN, FLEN - 1, 1'b0);
    t_nom = $time - t0;
    @(negedge clk);
    chk("nom_writes", 32'(wr_cnt), FLEN);
    chk("nom_addr",   32'(addr_err + ew_err), 32'd0);
    chk_image("nom_image", FLEN);
    chk("nom_flags",  {28'd0, busy, done, err_short, err_long}, 32'b0100);
    chk("nom_cnt",    32'(beat_cnt), FLEN);
    chk("nom_done_last_wr", 32'(done_at_wr), 32'd1);
    chk("nom_last_addr", 32'(bus.bram_addra), BASE + FLEN - 1);
    chk("nom_idle_wea", {30'd0, bus.bram_ena, bus.bram_wea}, 32'd0);
    chk("nom_tready", 32'(bus.s_axis_tready), 32'd0);

    // 2. Bubbles
    clr_mon();
    for (int i = 0; i < FLEN; i++) mem[i] = '0;
    arm();
    t0 = $time;
    stream(0, FLEN, FLEN - 1, 1'b1);
    t_bub = $time - t0;
    @(negedge clk);
    chk("bub_writes", 32'(wr_cnt), FLEN);
    chk("bub_addr",   32'(addr_err + ew_err), 32'd0);
    chk_image("bub_image", FLEN);
    chk("bub_flags",  {28'd0, busy, done, err_short, err_long}, 32'b0100);
    chk("bub_cnt",    32'(beat_cnt), FLEN);
    chk("bub_time",   32'((t_bub >= 2 * t_nom - 50) && (t_bub <= 2 * t_nom + 50)), 32'd1);

    // 3. Short frame
    clr_mon();
    arm();
    stream(0, 100, 99, 1'b0);
    @(negedge clk);
    chk("short_writes", 32'(wr_cnt), 32'd100);
    chk("short_addr",   32'(addr_err + ew_err), 32'd0);
    chk("short_flags",  {28'd0, busy, done, err_short, err_long}, 32'b0110);
    chk("short_cnt",    32'(beat_cnt), 32'd100);
    chk("short_last_addr", 32'(bus.bram_addra), BASE + 99);

    // 4. Long frame: 4810 beats, tlast on the last
    clr_mon();
    arm();
    stream(0, FLEN + 9, -1, 1'b0);
    @(negedge clk);
    chk("long_pre_flags", {28'd0, busy, done, err_short, err_long}, 32'b1001);
    chk("long_pre_cnt",   32'(beat_cnt), FLEN);
    stream(FLEN + 9, 1, FLEN + 9, 1'b0);
    @(negedge clk);
    chk("long_writes", 32'(wr_cnt), FLEN);
    chk("long_addr",   32'(addr_err + ew_err), 32'd0);
    chk("long_flags",  {28'd0, busy, done, err_short, err_long}, 32'b0101);
    chk("long_cnt",    32'(beat_cnt), FLEN);
    chk("long_done_at_wr", 32'(done_at_wr), 32'd0);
    chk("long_last_addr", 32'(bus.bram_addra), BASE + FLEN - 1);

    // 5. Arm rules: hold 0xAA, re-drive mid-frame, re-arm after done
    clr_mon();
    arm();
    stream(0, 2000, -1, 1'b0);
    gpio = 32'h0;
    @(negedge clk) gpio = 32'h0000_00AA;
    stream(2000, FLEN - 2000, FLEN - 1, 1'b0);
    repeat (110) @(negedge clk);
    chk("arm_writes", 32'(wr_cnt), FLEN);
    chk("arm_addr",   32'(addr_err + ew_err), 32'd0);
    chk("arm_hold_flags", {28'd0, busy, done, err_short, err_long}, 32'b0100);
    chk("arm_hold_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("arm_hold_cnt", 32'(beat_cnt), FLEN);
    clr_mon();
    arm();
    @(negedge clk);
    chk("rearm_flags", {28'd0, busy, done, err_short, err_long}, 32'b1000);
    chk("rearm_cnt", 32'(beat_cnt), 32'd0);
    stream(0, 10, 9, 1'b0);
    @(negedge clk);
    chk("rearm_writes", 32'(wr_cnt), 32'd10);
    chk("rearm_addr",   32'(addr_err + ew_err), 32'd0);

    // 6. Reset mid-frame
    clr_mon();
    arm();
    stream(0, 2001, -1, 1'b0);
    @(negedge clk);
    chk("mid_writes", 32'(wr_cnt), 32'd2001);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    gpio = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 32'(bus.s_axis_tready), 32'd0);
    clr_mon();
    arm();
    stream(0, 10, 9, 1'b0);
    @(negedge clk);
    chk("post_rst_writes", 32'(wr_cnt), 32'd10);
    chk("post_rst_addr",   32'(addr_err + ew_err), 32'd0);
    chk("post_rst_cnt",    32'(beat_cnt), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
